// File: rtl/toom_pkg.sv
// -----------------------------------------------------------------------------
// toom_pkg
// Shared definitions for the Toom-K pointwise multiplication stage.
//   toom_clog2  : ceiling log2, never below 1 (safe as a vector width)
//   toom_npts   : evaluation points per job for a given split count K (2K-1)
//   toom_prod_w : exact signed product width for a given operand width
//   TOOM_*      : derived constants for the reference configuration (K=8)
//   pw_state_t  : job sequencing states of the engine
// -----------------------------------------------------------------------------
package toom_pkg;

  function automatic int toom_clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res = res + 1;
    if (res < 1) res = 1;
    return res;
  endfunction

  function automatic int toom_npts(input int k);
    return 2 * k - 1;
  endfunction

  function automatic int toom_prod_w(input int eval_w);
    return 2 * eval_w;
  endfunction

  localparam int TOOM_K      = 8;
  localparam int TOOM_EVAL_W = 155;
  localparam int TOOM_NPTS   = toom_npts(TOOM_K);
  localparam int TOOM_IDX_W  = toom_clog2(TOOM_NPTS);
  localparam int TOOM_PROD_W = toom_prod_w(TOOM_EVAL_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } pw_state_t;

endpackage

// File: rtl/toom_pw_mul_pipe.sv
// -----------------------------------------------------------------------------
// toom_pw_mul_pipe
// MUL_LAT-stage signed multiplier, EVAL_W x EVAL_W -> 2*EVAL_W exact, with a
// tag side-band (point index, last flag) delayed alongside the product.
// The pipeline never stalls; a result leaves o_* MUL_LAT cycles after i_vld.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset (valid bits only)
//   i_vld, i_a, i_b     operand pair and its qualifier
//   i_idx, i_last       tag travelling with the pair
//   o_vld, o_prod       product and qualifier
//   o_idx, o_last       delayed tag
// -----------------------------------------------------------------------------
module toom_pw_mul_pipe #(
  parameter  int EVAL_W  = 155,
  parameter  int MUL_LAT = 4,
  parameter  int IDX_W   = 4,
  localparam int PROD_W  = 2 * EVAL_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_vld,
  input  logic signed [EVAL_W-1:0] i_a,
  input  logic signed [EVAL_W-1:0] i_b,
  input  logic        [IDX_W-1:0]  i_idx,
  input  logic                     i_last,
  output logic                     o_vld,
  output logic signed [PROD_W-1:0] o_prod,
  output logic        [IDX_W-1:0]  o_idx,
  output logic                     o_last
);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] r_prod_p [MUL_LAT];
  logic        [IDX_W-1:0]  r_idx_p  [MUL_LAT];
  logic                     r_last_p [MUL_LAT];
  logic        [MUL_LAT-1:0] r_vld_p;

  // Both operands are sign-extended to the full product width first, so the
  // multiply is exact and needs no post-correction.
  assign w_prod = $signed(PROD_W'(i_a)) * $signed(PROD_W'(i_b));

  // Stage p0: multiply; stages p1..p(MUL_LAT-1): retiming delay line
  always_ff @(posedge i_clk) begin
    r_prod_p[0] <= w_prod;
    r_idx_p[0]  <= i_idx;
    r_last_p[0] <= i_last;
    for (int s = 1; s < MUL_LAT; s++) begin
      r_prod_p[s] <= r_prod_p[s-1];
      r_idx_p[s]  <= r_idx_p[s-1];
      r_last_p[s] <= r_last_p[s-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_p <= '0;
    end else begin
      r_vld_p[0] <= i_vld;
      for (int s = 1; s < MUL_LAT; s++) r_vld_p[s] <= r_vld_p[s-1];
    end
  end

  assign o_vld  = r_vld_p[MUL_LAT-1];
  assign o_prod = r_prod_p[MUL_LAT-1];
  assign o_idx  = r_idx_p[MUL_LAT-1];
  assign o_last = r_last_p[MUL_LAT-1];

endmodule

// File: rtl/toom_pointwise_engine.sv
// -----------------------------------------------------------------------------
// toom_pointwise_engine
// Pointwise stage of a Toom-K multiplier: takes the 2K-1 evaluated operand
// pairs of a job, multiplies them through one shared pipelined signed
// multiplier and emits exact products tagged with their point index.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   s_valid/s_ready/s_a/s_b/s_last  operand pair stream (s_last is advisory)
//   m_valid/m_ready                 product stream handshake
//   m_prod/m_idx/m_last             product, point index, final-point flag
//   busy                            job in progress
//   done                            pulse on pop of the final product of a job
//   seq_err                         (TOOM_PW_SEQCHK_EN only) sticky flag for an
//                                   s_last that disagrees with the point index
// Build option: define TOOM_PW_SEQCHK_EN to add the seq_err checker.
// -----------------------------------------------------------------------------
module toom_pointwise_engine
  import toom_pkg::*;
#(
  parameter  int K          = 8,
  parameter  int EVAL_W     = 155,
  parameter  int MUL_LAT    = 4,
  parameter  int FIFO_DEPTH = 8,
  localparam int NPTS       = toom_npts(K),
  localparam int IDX_W      = toom_clog2(NPTS),
  localparam int PROD_W     = toom_prod_w(EVAL_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [EVAL_W-1:0] s_a,
  input  logic signed [EVAL_W-1:0] s_b,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [PROD_W-1:0] m_prod,
  output logic        [IDX_W-1:0]  m_idx,
  output logic                     m_last,
  output logic                     busy,
  output logic                     done
`ifdef TOOM_PW_SEQCHK_EN
  ,
  output logic                     seq_err
`endif
);

  localparam int PTR_W = toom_clog2(FIFO_DEPTH);
  localparam int CNT_W = toom_clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NPTS - 1);
  localparam logic [PTR_W-1:0] PTR_MAX   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(FIFO_DEPTH);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
  endfunction

  // handshake / credit
  logic               w_accept, w_pop, w_acc_last, w_pop_last, w_load;
  logic               r_s_ready;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_used, w_used_nxt;
  logic [CNT_W-1:0]   r_ends, w_ends_nxt;

  // multiplier output
  logic                     w_pipe_vld, w_pipe_last;
  logic signed [PROD_W-1:0] w_pipe_prod;
  logic        [IDX_W-1:0]  w_pipe_idx;

  // buffer storage behind the registered output
  logic signed [PROD_W-1:0] r_mem_prod [FIFO_DEPTH];
  logic        [IDX_W-1:0]  r_mem_idx  [FIFO_DEPTH];
  logic                     r_mem_last [FIFO_DEPTH];
  logic        [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic        [CNT_W-1:0]  r_mem_cnt;

  // registered output
  logic                     r_m_valid, r_m_last;
  logic signed [PROD_W-1:0] r_m_prod;
  logic        [IDX_W-1:0]  r_m_idx;

  pw_state_t r_state, w_state_nxt;
  logic      w_done;

  assign w_accept   = s_valid && r_s_ready;
  assign w_pop      = r_m_valid && m_ready;
  assign w_acc_last = w_accept && (r_idx == LAST_IDX);
  assign w_pop_last = w_pop && r_m_last;
  // Refill the output register whenever it is empty or being consumed.
  assign w_load     = (r_mem_cnt != '0) && (!r_m_valid || m_ready);

  // r_used counts every pair accepted but not yet popped (pipeline + buffer
  // + output register), so a full count guarantees room for all in-flight
  // products even while the consumer stalls.
  assign w_used_nxt = r_used + CNT_W'(w_accept) - CNT_W'(w_pop);
  // Number of final-point products accepted but not yet popped; lets the FSM
  // tell whether another job has already been fully accepted during a drain.
  assign w_ends_nxt = r_ends + CNT_W'(w_acc_last) - CNT_W'(w_pop_last);

  toom_pw_mul_pipe #(
    .EVAL_W  (EVAL_W),
    .MUL_LAT (MUL_LAT),
    .IDX_W   (IDX_W)
  ) u_mul (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_vld  (w_accept),
    .i_a    (s_a),
    .i_b    (s_b),
    .i_idx  (r_idx),
    .i_last (r_idx == LAST_IDX),
    .o_vld  (w_pipe_vld),
    .o_prod (w_pipe_prod),
    .o_idx  (w_pipe_idx),
    .o_last (w_pipe_last)
  );

  // Stage p(MUL_LAT): buffer write
  always_ff @(posedge clk) begin
    if (w_pipe_vld) begin
      r_mem_prod[r_wr_ptr] <= w_pipe_prod;
      r_mem_idx[r_wr_ptr]  <= w_pipe_idx;
      r_mem_last[r_wr_ptr] <= w_pipe_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_used    <= '0;
      r_ends    <= '0;
      r_s_ready <= 1'b0;
      r_idx     <= '0;
      r_state   <= ST_IDLE;
    end else begin
      if (w_pipe_vld) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_load)     r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_mem_cnt <= r_mem_cnt + CNT_W'(w_pipe_vld) - CNT_W'(w_load);
      r_used    <= w_used_nxt;
      r_ends    <= w_ends_nxt;
      r_s_ready <= (w_used_nxt < CNT_DEPTH);
      if (w_accept) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      r_state   <= w_state_nxt;
    end
  end

  // Stage p(MUL_LAT+1): registered output, held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_prod  <= '0;
      r_m_idx   <= '0;
      r_m_last  <= 1'b0;
    end else if (w_load) begin
      r_m_valid <= 1'b1;
      r_m_prod  <= r_mem_prod[r_rd_ptr];
      r_m_idx   <= r_mem_idx[r_rd_ptr];
      r_m_last  <= r_mem_last[r_rd_ptr];
    end else if (w_pop) begin
      r_m_valid <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = w_acc_last ? ST_DRAIN : ST_RUN;
      end
      ST_RUN: begin
        if (w_acc_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pop_last) begin
          w_done = 1'b1;
          // A following job may already be partly (or fully) accepted.
          if (w_ends_nxt != '0)                  w_state_nxt = ST_DRAIN;
          else if (w_accept || (r_idx != '0))    w_state_nxt = ST_RUN;
          else                                   w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign s_ready = r_s_ready;
  assign m_valid = r_m_valid;
  assign m_prod  = r_m_prod;
  assign m_idx   = r_m_idx;
  assign m_last  = r_m_last;
  assign busy    = (r_state != ST_IDLE);
  assign done    = w_done;

`ifdef TOOM_PW_SEQCHK_EN
  logic r_seq_err;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq_err <= 1'b0;
    end else if (w_accept && (s_last != (r_idx == LAST_IDX))) begin
      r_seq_err <= 1'b1;
    end
  end
  assign seq_err = r_seq_err;
`else
  logic w_unused_last;
  assign w_unused_last = s_last;
`endif

endmodule

// File: tb/tb_toom_pointwise_engine.sv
module tb_toom_pointwise_engine;
  import toom_pkg::*;

  localparam int K     = 8;
  localparam int EW    = 155;
  localparam int ML    = 4;
  localparam int DEPTH = 8;
  localparam int NPTS  = 2 * K - 1;
  localparam int IW    = 4;
  localparam int PW    = 2 * EW;

  logic                 clk, rst;
  logic                 s_valid, s_ready, s_last;
  logic signed [EW-1:0] s_a, s_b;
  logic                 m_valid, m_ready, m_last;
  logic signed [PW-1:0] m_prod;
  logic [IW-1:0]        m_idx;
  logic                 busy, done;
`ifdef TOOM_PW_SEQCHK_EN
  logic                 seq_err;
  bit                   seq_m;
`endif

  toom_pointwise_engine #(
    .K(K), .EVAL_W(EW), .MUL_LAT(ML), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_prod(m_prod), .m_idx(m_idx),
    .m_last(m_last), .busy(busy), .done(done)
`ifdef TOOM_PW_SEQCHK_EN
    , .seq_err(seq_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [PW-1:0] prod;
    int                   idx;
    bit                   last;
  } ent_t;

  ent_t q[$];      // expected products, accepted and not yet popped
  ent_t log_q[$];  // products actually popped, in order
  ent_t mon_e;

  int   n_cmp = 0, n_bad = 0;
  int   acc_cnt = 0, acc_total = 0, done_cnt = 0, cyc = 0;
  bit   lat_arm = 0;
  int   first_acc = -1, first_mv = -1;
  logic rst_q;
  bit   exp_done;

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Exact signed product from plain wide arithmetic.
  function automatic logic signed [PW-1:0] mulx(input logic signed [EW-1:0] a,
                                                input logic signed [EW-1:0] b);
    logic signed [PW-1:0] wa;
    wa = a;
    return wa * b;
  endfunction

  function automatic logic signed [EW-1:0] rnd_op();
    logic [159:0]         t;
    logic signed [EW-1:0] r;
    int                   m;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    m = $urandom_range(0, 7);
    r = t[EW-1:0];
    if (m == 0)      begin r = '0; r[EW-1] = 1'b1; end
    else if (m == 1) begin r = '1; r[EW-1] = 1'b0; end
    else if (m == 2) r = '1;
    return r;
  endfunction

  always @(posedge clk) rst_q <= rst;

  // Reference model and per-cycle compare, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst_q) begin
      chk("rst_s_ready", s_ready, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_prod", m_prod, 0);
      chk("rst_m_idx", m_idx, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
`ifdef TOOM_PW_SEQCHK_EN
      chk("rst_seq_err", seq_err, 0);
      seq_m = 0;
`endif
      q.delete();
      acc_cnt = 0;
    end else begin
      chk("s_ready", s_ready, (q.size() < DEPTH));
      chk("busy", busy, (q.size() != 0) || ((acc_cnt % NPTS) != 0));
`ifdef TOOM_PW_SEQCHK_EN
      chk("seq_err", seq_err, seq_m);
`endif
      exp_done = 0;
      if (m_valid) begin
        if (q.size() == 0) begin
          chk("m_valid_spurious", m_valid, 0);
        end else begin
          chk("m_prod", m_prod, q[0].prod);
          chk("m_idx", m_idx, q[0].idx);
          chk("m_last", m_last, q[0].last);
          exp_done = m_ready && q[0].last;
        end
      end
      chk("done", done, exp_done);
      if (done) done_cnt++;
      if (lat_arm && first_mv < 0 && m_valid) first_mv = cyc;
      if (!rst) begin
        if (m_valid && m_ready && q.size() > 0) begin
          mon_e.prod = m_prod; mon_e.idx = int'(m_idx); mon_e.last = m_last;
          log_q.push_back(mon_e);
          void'(q.pop_front());
        end
        if (s_valid && s_ready) begin
          if (lat_arm && first_acc < 0) first_acc = cyc;
          mon_e.prod = mulx(s_a, s_b);
          mon_e.idx  = acc_cnt % NPTS;
          mon_e.last = (mon_e.idx == NPTS - 1);
`ifdef TOOM_PW_SEQCHK_EN
          if (s_last != mon_e.last) seq_m = 1;
`endif
          q.push_back(mon_e);
          acc_cnt++;
          acc_total++;
        end
      end
    end
  end

  task automatic send(input logic signed [EW-1:0] a, input logic signed [EW-1:0] b,
                      input bit flip);
    int g;
    g = 0;
    s_valid = 1'b1; s_a = a; s_b = b;
    s_last = (((acc_cnt % NPTS) == NPTS - 1) ? 1'b1 : 1'b0) ^ flip;
    @(negedge clk);
    while (!s_ready && g < 300) begin @(negedge clk); g++; end
    if (g >= 300) chk("send_timeout", s_ready, 1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (q.size() != 0 && g < 500) begin @(posedge clk); g++; end
    #1;
    if (g >= 500) chk("drain_timeout", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int                   b, d0, a0;
  logic signed [EW-1:0] mn;
  logic signed [PW-1:0] e310;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: known job, p0 = 253*253, point inf = 8*8
    b = log_q.size(); d0 = done_cnt;
    send(253, 253, 0);
    for (int i = 1; i < NPTS - 1; i++) send(rnd_op(), rnd_op(), 0);
    send(8, 8, 0);
    wait_drain();
    chk("t1_count", log_q.size() - b, NPTS);
    chk("t1_p0", log_q[b].prod, 64009);
    chk("t1_idx0", log_q[b].idx, 0);
    chk("t1_p14", log_q[b+14].prod, 64);
    chk("t1_idx14", log_q[b+14].idx, 14);
    chk("t1_last14", log_q[b+14].last, 1);
    chk("t1_done_once", done_cnt - d0, 1);

    // 2: signed arithmetic
    b = log_q.size();
    mn = '0; mn[EW-1] = 1'b1;
    send(-3, 5, 0);
    send(mn, mn, 0);
    for (int i = 2; i < NPTS; i++) send(rnd_op(), rnd_op(), 0);
    wait_drain();
    e310 = -15;
    chk("t2_neg15", log_q[b].prod, e310);
    e310 = '0; e310[308] = 1'b1;
    chk("t2_2pow308", log_q[b+1].prod, e310);

    // 3: consumer stalled, producer keeps offering
    b = log_q.size(); a0 = acc_total;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_a = rnd_op(); s_b = rnd_op();
      s_last = ((acc_cnt % NPTS) == NPTS - 1);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk("t3_accepted", acc_total - a0, DEPTH);
    chk("t3_s_ready_low", s_ready, 0);
    chk("t3_none_popped", log_q.size() - b, 0);
    m_ready = 1'b1;
    for (int i = DEPTH; i < NPTS; i++) send(rnd_op(), rnd_op(), 0);
    wait_drain();
    chk("t3_all_out", log_q.size() - b, NPTS);

    // 4: two jobs back to back
    b = log_q.size(); d0 = done_cnt;
    lat_arm = 1; first_acc = -1; first_mv = -1;
    for (int i = 0; i < 2 * NPTS; i++) send(rnd_op(), rnd_op(), 0);
    wait_drain();
    lat_arm = 0;
    for (int i = 0; i < 2 * NPTS; i++) chk("t4_idx", log_q[b+i].idx, i % NPTS);
    chk("t4_done_twice", done_cnt - d0, 2);
    // accept observed in the cycle before its transfer edge
    chk("t4_latency", first_mv - (first_acc + 1), ML + 1);

    // 5: reset in the middle of a job with products buffered
    m_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(rnd_op(), rnd_op(), 0);
    do_reset();
    chk("t5_m_valid", m_valid, 0);
    chk("t5_busy", busy, 0);
    m_ready = 1'b1;
    @(posedge clk); #1;
    b = log_q.size();
    send(7, 9, 0);
    wait_drain();
    chk("t5_idx_restart", log_q[b].idx, 0);
    chk("t5_prod", log_q[b].prod, 63);

    // random traffic with random consumer stalls
    for (int i = 0; i < 400; i++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_a = rnd_op(); s_b = rnd_op();
      s_last = ((acc_cnt % NPTS) == NPTS - 1);
      m_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0; m_ready = 1'b1;
    wait_drain();

`ifdef TOOM_PW_SEQCHK_EN
    // 6: misplaced s_last on point 5
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NPTS; i++) send(rnd_op(), rnd_op(), (i == 5));
    wait_drain();
    chk("t6_seq_err_set", seq_err, 1);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_seq_err_sticky", seq_err, 1);
    do_reset();
    chk("t6_seq_err_cleared", seq_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
